// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register-file write path and its arbiters.
package reg_file_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 4;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Requester IDs double as bit positions in the valid/grant vectors.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the priority requester wins a tie, and the pointer
// moves to the other requester after any grant.
module rr_arb2
  import reg_file_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_pri,
  output logic [1:0] o_grant,
  output logic       o_pri_next
);

  always_comb begin
    o_grant = 2'b00;
    if (&i_valid) begin
      o_grant[i_pri] = 1'b1;
    end else begin
      o_grant = i_valid;
    end
  end

  always_comb begin
    o_pri_next = i_pri;
    if (o_grant[REQ_ALU]) begin
      o_pri_next = REQ_MEM;
    end else if (o_grant[REQ_MEM]) begin
      o_pri_next = REQ_ALU;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between ALU writeback and memory load,
// optionally clearing R1..R(2**AW-1) after reset. All RF outputs are registered.
module reg_write_arbiter
  import reg_file_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int AW         = AW_DEFAULT,
  parameter int INIT_CLEAR = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0_VALID,
  output logic          REQ0_READY,
  input  logic [AW-1:0] REQ0_ADDR,
  input  logic [DW-1:0] REQ0_DATA,
  input  logic          REQ1_VALID,
  output logic          REQ1_READY,
  input  logic [AW-1:0] REQ1_ADDR,
  input  logic [DW-1:0] REQ1_DATA,
  output logic          RF_WE,
  output logic [AW-1:0] RF_WA,
  output logic [DW-1:0] RF_WD,
  output logic          BUSY,
  output state_t        DBG_STATE
);

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = '1;
  localparam logic [AW-1:0] ADDR_R0   = AW'(REG_ZERO);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_pri;
  logic          r_we;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_wd;

  logic          w_arb_en;
  logic [1:0]    w_req_valid;
  logic [1:0]    w_grant;
  logic          w_pri_next;
  logic          w_xfer;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;
  logic          w_wr;

  // Handshake: a transfer happens when VALIDi and READYi are both high at a posedge.
  // READY is combinational from VALID and is never high during reset or INIT.
  // A requester holds ADDR/DATA stable while VALID is high and READY is low;
  // withdrawing VALID before READY is allowed and writes nothing.
  assign w_arb_en    = RST_N && (r_state == S_RUN);
  assign w_req_valid = {REQ1_VALID, REQ0_VALID} & {2{w_arb_en}};

  rr_arb2 u_arb (
    .i_valid    (w_req_valid),
    .i_pri      (r_pri),
    .o_grant    (w_grant),
    .o_pri_next (w_pri_next)
  );

  assign REQ0_READY = w_grant[REQ_ALU];
  assign REQ1_READY = w_grant[REQ_MEM];

  assign w_xfer     = |w_grant;
  assign w_sel_addr = w_grant[REQ_MEM] ? REQ1_ADDR : REQ0_ADDR;
  assign w_sel_data = w_grant[REQ_MEM] ? REQ1_DATA : REQ0_DATA;
  // R0 is hardwired zero: the grant is consumed but no write is issued.
  assign w_wr       = w_xfer && (w_sel_addr != ADDR_R0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
      r_cnt   <= CNT_FIRST;
      r_pri   <= REQ_ALU;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_we  <= 1'b1;
          r_wa  <= r_cnt;
          r_wd  <= '0;
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_we  <= w_wr;
          r_pri <= w_pri_next;
          if (w_wr) begin
            r_wa <= w_sel_addr;
            r_wd <= w_sel_data;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign RF_WE     = r_we;
  assign RF_WA     = r_wa;
  assign RF_WD     = r_wd;
  assign BUSY      = (r_state == S_INIT);
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural 16x8 register file
// that writes on the negedge from RF_WE/RF_WA/RF_WD.
module tb_reg_write_arbiter;
  import reg_file_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          REQ0_VALID, REQ0_READY;
  logic [AW-1:0] REQ0_ADDR;
  logic [DW-1:0] REQ0_DATA;
  logic          REQ1_VALID, REQ1_READY;
  logic [AW-1:0] REQ1_ADDR;
  logic [DW-1:0] REQ1_DATA;
  logic          RF_WE;
  logic [AW-1:0] RF_WA;
  logic [DW-1:0] RF_WD;
  logic          BUSY;
  state_t        DBG_STATE;

  logic [DW-1:0] rf [16];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  reg_write_arbiter #(.DW(DW), .AW(AW), .INIT_CLEAR(1)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_ADDR  (REQ0_ADDR),
    .REQ0_DATA  (REQ0_DATA),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_ADDR  (REQ1_ADDR),
    .REQ1_DATA  (REQ1_DATA),
    .RF_WE      (RF_WE),
    .RF_WA      (RF_WA),
    .RF_WD      (RF_WD),
    .BUSY       (BUSY),
    .DBG_STATE  (DBG_STATE)
  );

  // Register file model: writes any address, so a stray R0 write is visible.
  always @(negedge CLK) begin
    if (RF_WE) rf[RF_WA] <= RF_WD;
  end

  // ---------------- driver ----------------
  task automatic set_inputs(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    REQ0_VALID = v0; REQ0_ADDR = a0; REQ0_DATA = d0;
    REQ1_VALID = v1; REQ1_ADDR = a1; REQ1_DATA = d1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    set_inputs(1'b1, 4'd3, 8'h12, 1'b1, 4'd5, 8'h34);
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", RF_WE); end
    n_cmp++; if (RF_WA !== 4'd0) begin n_err++; $display("FAIL reset_wa got %0d want 0", RF_WA); end
    n_cmp++; if (RF_WD !== 8'h00) begin n_err++; $display("FAIL reset_wd got %h want 00", RF_WD); end
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", BUSY); end
    n_cmp++; if (DBG_STATE !== S_INIT) begin n_err++; $display("FAIL reset_state got %b want %b", DBG_STATE, S_INIT); end
    n_cmp++; if (REQ0_READY !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %b want 0", REQ0_READY); end
    n_cmp++; if (REQ1_READY !== 1'b0) begin n_err++; $display("FAIL reset_ready1 got %b want 0", REQ1_READY); end
    set_inputs(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic test_init_clear();
    logic exp_busy;
    rf[0] = 8'h00;
    for (int r = 1; r < 16; r++) rf[r] = 8'hFF;
    RST_N = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge CLK); #1;
      exp_busy = (i < 15);
      n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL init_we[%0d] got %b want 1", i, RF_WE); end
      n_cmp++; if (RF_WA !== 4'(i)) begin n_err++; $display("FAIL init_wa[%0d] got %0d want %0d", i, RF_WA, i); end
      n_cmp++; if (RF_WD !== 8'h00) begin n_err++; $display("FAIL init_wd[%0d] got %h want 00", i, RF_WD); end
      n_cmp++; if (BUSY !== exp_busy) begin n_err++; $display("FAIL init_busy[%0d] got %b want %b", i, BUSY, exp_busy); end
    end
    @(negedge CLK); #1;
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL init_done_we got %b want 0", RF_WE); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL init_done_busy got %b want 0", BUSY); end
    n_cmp++; if (DBG_STATE !== S_RUN) begin n_err++; $display("FAIL init_done_state got %b want %b", DBG_STATE, S_RUN); end
    for (int r = 1; r < 16; r++) begin
      n_cmp++; if (rf[r] !== 8'h00) begin n_err++; $display("FAIL init_clear_r%0d got %h want 00", r, rf[r]); end
    end
  endtask

  task automatic test_single();
    set_inputs(1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'h00);
    #1;
    n_cmp++; if (REQ0_READY !== 1'b1) begin n_err++; $display("FAIL single_ready0 got %b want 1", REQ0_READY); end
    n_cmp++; if (REQ1_READY !== 1'b0) begin n_err++; $display("FAIL single_ready1 got %b want 0", REQ1_READY); end
    @(negedge CLK);
    set_inputs(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1;
    n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL single_we got %b want 1", RF_WE); end
    n_cmp++; if (RF_WA !== 4'd3) begin n_err++; $display("FAIL single_wa got %0d want 3", RF_WA); end
    n_cmp++; if (RF_WD !== 8'h5A) begin n_err++; $display("FAIL single_wd got %h want 5a", RF_WD); end
    n_cmp++; if (rf[3] !== 8'h5A) begin n_err++; $display("FAIL single_r3 got %h want 5a", rf[3]); end
    @(negedge CLK); #1;
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL single_idle_we got %b want 0", RF_WE); end
  endtask

  task automatic test_addr_zero();
    set_inputs(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'hEE);
    #1;
    n_cmp++; if (REQ1_READY !== 1'b1) begin n_err++; $display("FAIL r0_ready1 got %b want 1", REQ1_READY); end
    n_cmp++; if (REQ0_READY !== 1'b0) begin n_err++; $display("FAIL r0_ready0 got %b want 0", REQ0_READY); end
    @(negedge CLK);
    set_inputs(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1;
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL r0_we got %b want 0", RF_WE); end
    n_cmp++; if (rf[0] !== 8'h00) begin n_err++; $display("FAIL r0_value got %h want 00", rf[0]); end
  endtask

  // Expects PRI=0 on entry (left there by the R0 transfer from MEM).
  task automatic test_round_robin();
    logic [AW-1:0] alu_a [3];
    logic [DW-1:0] alu_d [3];
    logic [AW-1:0] mem_a [3];
    logic [DW-1:0] mem_d [3];
    logic          exp_g [4];
    logic [AW-1:0] exp_wa [4];
    logic [DW-1:0] exp_wd [4];
    int ai, mi;
    alu_a = '{4'd1, 4'd2, 4'd3};  alu_d = '{8'h11, 8'h22, 8'h33};
    mem_a = '{4'd5, 4'd6, 4'd7};  mem_d = '{8'hA0, 8'hA1, 8'hA2};
    exp_g  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_wa = '{4'd1, 4'd5, 4'd2, 4'd6};
    exp_wd = '{8'h11, 8'hA0, 8'h22, 8'hA1};
    ai = 0; mi = 0;
    for (int c = 0; c < 4; c++) begin
      set_inputs(1'b1, alu_a[ai], alu_d[ai], 1'b1, mem_a[mi], mem_d[mi]);
      #1;
      n_cmp++; if (REQ0_READY !== (exp_g[c] == 1'b0)) begin n_err++; $display("FAIL rr_ready0[%0d] got %b want %b", c, REQ0_READY, exp_g[c] == 1'b0); end
      n_cmp++; if (REQ1_READY !== (exp_g[c] == 1'b1)) begin n_err++; $display("FAIL rr_ready1[%0d] got %b want %b", c, REQ1_READY, exp_g[c] == 1'b1); end
      if (REQ0_READY === 1'b1 && ai < 2) ai++;
      if (REQ1_READY === 1'b1 && mi < 2) mi++;
      @(negedge CLK); #1;
      n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL rr_we[%0d] got %b want 1", c, RF_WE); end
      n_cmp++; if (RF_WA !== exp_wa[c]) begin n_err++; $display("FAIL rr_wa[%0d] got %0d want %0d", c, RF_WA, exp_wa[c]); end
      n_cmp++; if (RF_WD !== exp_wd[c]) begin n_err++; $display("FAIL rr_wd[%0d] got %h want %h", c, RF_WD, exp_wd[c]); end
    end
    set_inputs(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    @(negedge CLK); #1;
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL rr_idle_we got %b want 0", RF_WE); end
    n_cmp++; if (rf[1] !== 8'h11) begin n_err++; $display("FAIL rr_r1 got %h want 11", rf[1]); end
    n_cmp++; if (rf[2] !== 8'h22) begin n_err++; $display("FAIL rr_r2 got %h want 22", rf[2]); end
    n_cmp++; if (rf[3] !== 8'h5A) begin n_err++; $display("FAIL rr_r3 got %h want 5a", rf[3]); end
    n_cmp++; if (rf[5] !== 8'hA0) begin n_err++; $display("FAIL rr_r5 got %h want a0", rf[5]); end
    n_cmp++; if (rf[6] !== 8'hA1) begin n_err++; $display("FAIL rr_r6 got %h want a1", rf[6]); end
  endtask

  // An ALU-only write first moves PRI to MEM, so the tie goes to MEM.
  task automatic test_same_addr();
    set_inputs(1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 8'h00);
    #1;
    n_cmp++; if (REQ0_READY !== 1'b1) begin n_err++; $display("FAIL same_setup_ready0 got %b want 1", REQ0_READY); end
    @(negedge CLK);
    set_inputs(1'b1, 4'd7, 8'h01, 1'b1, 4'd7, 8'h02);
    #1;
    n_cmp++; if (RF_WA !== 4'd4 || RF_WD !== 8'h44) begin n_err++; $display("FAIL same_setup_wr got %0d/%h want 4/44", RF_WA, RF_WD); end
    n_cmp++; if (REQ1_READY !== 1'b1) begin n_err++; $display("FAIL same_first_ready1 got %b want 1", REQ1_READY); end
    n_cmp++; if (REQ0_READY !== 1'b0) begin n_err++; $display("FAIL same_first_ready0 got %b want 0", REQ0_READY); end
    @(negedge CLK);
    set_inputs(1'b1, 4'd7, 8'h01, 1'b0, 4'd0, 8'h00);
    #1;
    n_cmp++; if (RF_WE !== 1'b1 || RF_WA !== 4'd7 || RF_WD !== 8'h02) begin n_err++; $display("FAIL same_first_wr got %b/%0d/%h want 1/7/02", RF_WE, RF_WA, RF_WD); end
    n_cmp++; if (REQ0_READY !== 1'b1) begin n_err++; $display("FAIL same_second_ready0 got %b want 1", REQ0_READY); end
    @(negedge CLK);
    set_inputs(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1;
    n_cmp++; if (RF_WE !== 1'b1 || RF_WA !== 4'd7 || RF_WD !== 8'h01) begin n_err++; $display("FAIL same_second_wr got %b/%0d/%h want 1/7/01", RF_WE, RF_WA, RF_WD); end
    n_cmp++; if (rf[7] !== 8'h01) begin n_err++; $display("FAIL same_r7 got %h want 01", rf[7]); end
    n_cmp++; if (rf[4] !== 8'h44) begin n_err++; $display("FAIL same_r4 got %h want 44", rf[4]); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int we_cnt;
    logic [AW-1:0] last_wa;
    // Reset in the middle of INIT, just after WA=6 was issued.
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    #1;
    n_cmp++; if (RF_WA !== 4'd6) begin n_err++; $display("FAIL mid_pre_wa got %0d want 6", RF_WA); end
    RST_N = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if (RF_WE !== 1'b0 || RF_WA !== 4'd0) begin n_err++; $display("FAIL mid_rst_out got %b/%0d want 0/0", RF_WE, RF_WA); end
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL mid_rst_busy got %b want 1", BUSY); end
    RST_N = 1'b1;
    @(negedge CLK); #1;
    n_cmp++; if (RF_WE !== 1'b1 || RF_WA !== 4'd1) begin n_err++; $display("FAIL mid_restart got %b/%0d want 1/1", RF_WE, RF_WA); end
    we_cnt = 1; last_wa = RF_WA;
    repeat (15) begin
      @(negedge CLK); #1;
      if (RF_WE === 1'b1) begin we_cnt++; last_wa = RF_WA; end
    end
    n_cmp++; if (we_cnt !== 15) begin n_err++; $display("FAIL mid_init_len got %0d want 15", we_cnt); end
    n_cmp++; if (last_wa !== 4'd15) begin n_err++; $display("FAIL mid_init_last got %0d want 15", last_wa); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL mid_run_busy got %b want 0", BUSY); end
    // Valid request presented while reset is asserted: must be dropped.
    set_inputs(1'b1, 4'd9, 8'h77, 1'b0, 4'd0, 8'h00);
    RST_N = 1'b0;
    #1;
    n_cmp++; if (REQ0_READY !== 1'b0) begin n_err++; $display("FAIL drop_ready0 got %b want 0", REQ0_READY); end
    @(negedge CLK);
    set_inputs(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    RST_N = 1'b1;
    #1;
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL drop_we got %b want 0", RF_WE); end
    we_cnt = 0;
    repeat (16) begin
      @(negedge CLK); #1;
      if (RF_WE === 1'b1) we_cnt++;
    end
    n_cmp++; if (we_cnt !== 15) begin n_err++; $display("FAIL drop_init_len got %0d want 15", we_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_init_clear();
    test_single();
    test_addr_zero();
    test_round_robin();
    test_same_addr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d compared, %0d errors", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
